// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// and the access legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_t;

  // Fields kept after accept; the word index is held separately since its width is a parameter.
  typedef struct packed {
    logic [1:0] off;
    logic [2:0] funct3;
  } lat_req_t;

  function automatic logic access_err(input logic [31:0] addr, input logic is_store,
                                      input logic [2:0] f3, input int unsigned depth);
    logic bad;
    bad = ((addr >> 2) >= depth);
    if (is_store) begin
      case (f3)
        F3_B:    bad = bad;
        F3_H:    bad = bad | addr[0];
        F3_W:    bad = bad | (|addr[1:0]);
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: bad = bad;
        F3_H, F3_HU: bad = bad | addr[0];
        F3_W:        bad = bad | (|addr[1:0]);
        default:     bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Aligns and extends load data from a RAM word; purely combinational so the
// writeback stage can reuse it.
module load_extract
  import dmem_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = rword >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? rword[31:16] : rword[15:0];
    case (funct3)
      F3_B:    rdata = {{24{b[7]}}, b};
      F3_H:    rdata = {{16{h[15]}}, h};
      F3_W:    rdata = rword;
      F3_BU:   rdata = {24'h0, b};
      F3_HU:   rdata = {16'h0, h};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: owns the word RAM, performs byte-lane stores and
// returns extracted load data with one response per accepted request.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  state_t      state;
  lat_req_t    req_q;
  logic [AW-1:0] idx_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rword;
  logic [31:0] ext_rdata;
  logic        accept, is_store, err, wr_en;
  logic [AW-1:0] widx;

  assign accept   = req_valid & req_ready;
  assign is_store = |req_we;
  assign err      = access_err(req_addr, is_store, req_funct3, DEPTH_WORDS);
  assign widx     = req_addr[AW+1:2];
  // Store lands on the accept edge, so a load right behind it sees the new data.
  assign wr_en    = accept & is_store & ~err & ~reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (req_we[i]) mem[widx][8*i +: 8] <= req_wdata[8*i +: 8];
    end
  end

  assign rword = mem[idx_q];

  load_extract u_ext (
    .rword  (rword),
    .off    (req_q.off),
    .funct3 (req_q.funct3),
    .rdata  (ext_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      req_q      <= '0;
      idx_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_q.off    <= req_addr[1:0];
            req_q.funct3 <= req_funct3;
            idx_q        <= widx;
            req_ready    <= 1'b0;
            if (err || is_store) begin
              resp_valid <= 1'b1;
              resp_err   <= err;
              resp_rdata <= 32'h0;
              state      <= S_RESP;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          resp_rdata <= ext_rdata;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stores, loads, extraction, errors,
// backpressure and reset mid-transaction.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int vectors = 0;
  int errs    = 0;

  dmem_responder #(.DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [3:0] we,
                           input logic [31:0] wd, input logic [2:0] f3);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; req_funct3 = f3;
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = 32'hx; req_we = 4'hx; req_wdata = 32'hx;
  endtask

  // Issues one request, waits (bounded) for the response and accepts it.
  task automatic xact(input string tag, input logic [31:0] a, input logic [3:0] we,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat;
    drive_req(a, we, wd, f3);
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".err"}, {31'h0, resp_err}, {31'h0, exp_err});
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = 32'h0; req_we = 4'h0; req_wdata = 32'h0; req_funct3 = 3'b000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.req_ready",  {31'h0, req_ready},  32'h1);
    chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst.resp_rdata", resp_rdata,           32'h0);
    chk("rst.resp_err",   {31'h0, resp_err},   32'h0);

    // Store then load (load: READ cycle then RESP; store goes straight to RESP).
    xact("sw10",  32'h10, 4'hF, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 1);
    xact("lw10",  32'h10, 4'h0, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 2);
    xact("lb13",  32'h13, 4'h0, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0, 2);
    xact("lbu13", 32'h13, 4'h0, 32'h0,        3'b100, 32'h000000DE, 1'b0, 2);
    xact("lh12",  32'h12, 4'h0, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0, 2);
    xact("lhu10", 32'h10, 4'h0, 32'h0,        3'b101, 32'h0000BEEF, 1'b0, 2);
    xact("lbu11", 32'h11, 4'h0, 32'h0,        3'b100, 32'h000000BE, 1'b0, 2);

    // Lane store.
    xact("sb11",  32'h11, 4'b0010, 32'h55555555, 3'b000, 32'h0, 1'b0, 1);
    xact("lw10b", 32'h10, 4'h0, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 2);

    // Misalignment and illegal codes.
    xact("lw12",    32'h12, 4'h0,    32'h0,        3'b010, 32'h0, 1'b1, 1);
    xact("lh11",    32'h11, 4'h0,    32'h0,        3'b001, 32'h0, 1'b1, 1);
    xact("sh13",    32'h13, 4'b1000, 32'h12341234, 3'b001, 32'h0, 1'b1, 1);
    xact("lw10c",   32'h10, 4'h0,    32'h0,        3'b010, 32'hDEAD55EF, 1'b0, 2);
    xact("f3_011",  32'h10, 4'h0,    32'h0,        3'b011, 32'h0, 1'b1, 1);
    xact("st_f3bu", 32'h10, 4'b0001, 32'h77777777, 3'b100, 32'h0, 1'b1, 1);
    xact("lw10d",   32'h10, 4'h0,    32'h0,        3'b010, 32'hDEAD55EF, 1'b0, 2);

    // Range boundary: last word is legal, 0x1000 is rejected and must not alias word 0.
    xact("sw0",    32'h0,    4'hF, 32'h11111111, 3'b010, 32'h0, 1'b0, 1);
    xact("swFFC",  32'hFFC,  4'hF, 32'hA5A5A5A5, 3'b010, 32'h0, 1'b0, 1);
    xact("sw1000", 32'h1000, 4'hF, 32'hCAFEF00D, 3'b010, 32'h0, 1'b1, 1);
    xact("lw0",    32'h0,    4'h0, 32'h0,        3'b010, 32'h11111111, 1'b0, 2);
    xact("lwFFC",  32'hFFC,  4'h0, 32'h0,        3'b010, 32'hA5A5A5A5, 1'b0, 2);

    // Backpressure: response held for 5 cycles.
    drive_req(32'h10, 4'h0, 32'h0, 3'b010);
    begin
      int lat;
      for (lat = 1; lat <= 10; lat++) begin
        @(negedge clk);
        if (resp_valid) break;
      end
      chk("bp.lat", 32'(lat), 32'd2);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("bp.resp_rdata", resp_rdata,           32'hDEAD55EF);
      chk("bp.resp_err",   {31'h0, resp_err},   32'h0);
      chk("bp.req_ready",  {31'h0, req_ready},  32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("bp.after.req_ready",  {31'h0, req_ready},  32'h1);
    chk("bp.after.resp_valid", {31'h0, resp_valid}, 32'h0);

    // Reset while in READ drops the response.
    drive_req(32'h0, 4'h0, 32'h0, 3'b010);
    @(negedge clk);
    chk("rd.in_read.resp_valid", {31'h0, resp_valid}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rd.rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rd.rst.req_ready",  {31'h0, req_ready},  32'h1);
    @(negedge clk);
    chk("rd.rst.stay_idle",  {31'h0, resp_valid}, 32'h0);

    // RAM survives reset.
    xact("lw10e", 32'h10, 4'h0, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
